// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM states,
// forwarding select codes and the register-dependency test used by every path.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hazard_ctl_t;

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic dep_hit(input logic [4:0] rd,
                                   input logic [4:0] rs,
                                   input logic       we);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding mux select for one Execute-stage source register.
// Memory stage holds the younger result, so it wins over Writeback.
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_reg_write_m,
  input  logic       i_reg_write_w,
  output logic [1:0] o_fwd
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    o_fwd = FWD_RF;
    if (dep_hit(i_rd_m, i_rs, i_reg_write_m)) begin
      o_fwd = FWD_M;
    end else if (dep_hit(i_rd_w, i_rs, i_reg_write_w)) begin
      o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: forwarding, load-use stall, branch flush,
// and a data-memory wait FSM with timeout fault and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE0,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT + 1);

  state_e             r_state;
  state_e             w_next_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [WAIT_W-1:0]  w_wait_cnt_next;
  logic               r_mem_fault;
  logic [CNT_W-1:0]   r_stall_cycles;
  logic               w_lw;
  logic               w_mbusy;
  logic [1:0]         w_fwd_a;
  logic [1:0]         w_fwd_b;
  hazard_ctl_t        w_ctl;

  fwd_sel u_fwd_a (
    .i_rs          (Rs1E),
    .i_rd_m        (RdM),
    .i_rd_w        (RdW),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_fwd         (w_fwd_a)
  );

  fwd_sel u_fwd_b (
    .i_rs          (Rs2E),
    .i_rd_m        (RdM),
    .i_rd_w        (RdW),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_fwd         (w_fwd_b)
  );

  assign w_lw    = ResultSrcE0 &
                   (dep_hit(RdE, Rs1D, 1'b1) | dep_hit(RdE, Rs2D, 1'b1));
  assign w_mbusy = MemAccessM & ~dmem_ready & (r_state != FAULT);

  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_ctl           = '0;

    unique case (r_state)
      RUN: begin
        if (w_mbusy) begin
          w_next_state    = MWAIT;
          w_wait_cnt_next = WAIT_W'(1);
        end
      end
      MWAIT: begin
        // A withdrawn access releases the freeze just like a completed one.
        if (!w_mbusy) begin
          w_next_state    = RUN;
          w_wait_cnt_next = '0;
        end else if (r_wait_cnt == WAIT_W'(DMEM_TIMEOUT)) begin
          w_next_state    = FAULT;
        end else begin
          w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
        end
      end
      FAULT: w_next_state = FAULT;
      default: begin
        w_next_state    = RUN;
        w_wait_cnt_next = '0;
      end
    endcase

    // Control outputs are forced quiet while reset is held.
    if (!reset_n) begin
      w_ctl = '0;
    end else if (r_state == FAULT) begin
      w_ctl.stall_f = 1'b1;
      w_ctl.stall_d = 1'b1;
      w_ctl.stall_e = 1'b1;
      w_ctl.stall_m = 1'b1;
    end else if (w_mbusy) begin
      w_ctl.stall_f = 1'b1;
      w_ctl.stall_d = 1'b1;
      w_ctl.stall_e = 1'b1;
      w_ctl.stall_m = 1'b1;
      w_ctl.flush_w = 1'b1;
    end else begin
      w_ctl.stall_f = w_lw & ~PCSrcE;
      w_ctl.stall_d = w_lw & ~PCSrcE;
      w_ctl.flush_d = PCSrcE;
      w_ctl.flush_e = w_lw | PCSrcE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_mem_fault <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
      r_state     <= w_next_state;
      r_wait_cnt  <= w_wait_cnt_next;
      r_mem_fault <= r_mem_fault | (w_next_state == FAULT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
    end else if (w_ctl.stall_f && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign ForwardAE    = reset_n ? w_fwd_a : FWD_RF;
  assign ForwardBE    = reset_n ? w_fwd_b : FWD_RF;
  assign StallF       = w_ctl.stall_f;
  assign StallD       = w_ctl.stall_d;
  assign StallE       = w_ctl.stall_e;
  assign StallM       = w_ctl.stall_m;
  assign FlushD       = w_ctl.flush_d;
  assign FlushE       = w_ctl.flush_e;
  assign FlushW       = w_ctl.flush_w;
  assign mem_fault    = r_mem_fault;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding, load-use, branch flush,
// memory wait, timeout fault, priority and counter saturation (CNT_W=4 copy).
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, dmem_ready;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_fault;
  logic [31:0] stall_cycles;

  logic [1:0]  s_fwd_a, s_fwd_b;
  logic        s_stall_f, s_stall_d, s_stall_e, s_stall_m;
  logic        s_flush_d, s_flush_e, s_flush_w, s_mem_fault;
  logic [3:0]  s_stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  wire [6:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  localparam logic [6:0] CTL_NONE   = 7'b000_0000;
  localparam logic [6:0] CTL_LW     = 7'b110_0010;
  localparam logic [6:0] CTL_BRANCH = 7'b000_0110;
  localparam logic [6:0] CTL_MBUSY  = 7'b111_1001;
  localparam logic [6:0] CTL_FAULT  = 7'b111_1000;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_fault(mem_fault), .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
    .ForwardAE(s_fwd_a), .ForwardBE(s_fwd_b),
    .StallF(s_stall_f), .StallD(s_stall_d), .StallE(s_stall_e), .StallM(s_stall_m),
    .FlushD(s_flush_d), .FlushE(s_flush_e), .FlushW(s_flush_w),
    .mem_fault(s_mem_fault), .stall_cycles(s_stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE  = '0; RdM  = '0; RdW  = '0;
    ResultSrcE0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; MemAccessM = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset_n = 1'b0;

    // Reset: outputs quiet even with every hazard source active.
    @(negedge clk);
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
    ResultSrcE0 = 1'b1; RdE = 5'd3; Rs2D = 5'd3; PCSrcE = 1'b1;
    MemAccessM = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    check("rst_fwd_a", 32'(ForwardAE), 32'(FWD_RF));
    check("rst_fwd_b", 32'(ForwardBE), 32'(FWD_RF));
    check("rst_ctl", 32'(ctl), 32'(CTL_NONE));
    check("rst_fault", 32'(mem_fault), 32'd0);
    check("rst_cnt", stall_cycles, 32'd0);
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Forwarding: M beats W, then W alone, then x0 never forwards.
    @(negedge clk);
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
    #1 check("fwd_a_m", 32'(ForwardAE), 32'(FWD_M));
    RegWriteM = 1'b0;
    #1 check("fwd_a_w", 32'(ForwardAE), 32'(FWD_W));
    Rs1E = 5'd0;
    #1 check("fwd_a_rf", 32'(ForwardAE), 32'(FWD_RF));
    Rs2E = 5'd9; RdM = 5'd9; RegWriteM = 1'b1; RdW = 5'd4;
    #1 check("fwd_b_m", 32'(ForwardBE), 32'(FWD_M));
    RdM = 5'd0; RdW = 5'd9;
    #1 check("fwd_b_w_rdm0", 32'(ForwardBE), 32'(FWD_W));
    RegWriteW = 1'b0;
    #1 check("fwd_b_rf", 32'(ForwardBE), 32'(FWD_RF));
    clear_inputs();

    // Load-use, branch override, and a load to x0 that must not stall.
    ResultSrcE0 = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
    #1 check("lw_stall", 32'(ctl), 32'(CTL_LW));
    PCSrcE = 1'b1;
    #1 check("lw_branch", 32'(ctl), 32'(CTL_BRANCH));
    PCSrcE = 1'b0; Rs2D = 5'd0; Rs1D = 5'd3;
    #1 check("lw_rs1", 32'(ctl), 32'(CTL_LW));
    RdE = 5'd0; Rs1D = 5'd0;
    #1 check("lw_x0", 32'(ctl), 32'(CTL_NONE));
    clear_inputs();

    // Single-cycle memory access adds no stall.
    MemAccessM = 1'b1; dmem_ready = 1'b1;
    #1 check("mem_1cyc_ctl", 32'(ctl), 32'(CTL_NONE));
    @(negedge clk);
    check("mem_1cyc_cnt", stall_cycles, 32'd0);
    clear_inputs();

    // Memory wait: 4 busy cycles then ready.
    pulse_reset();
    MemAccessM = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1 check($sformatf("mwait_ctl_%0d", i), 32'(ctl), 32'(CTL_MBUSY));
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1 check("mwait_release_ctl", 32'(ctl), 32'(CTL_NONE));
    check("mwait_cnt", stall_cycles, 32'd4);
    @(negedge clk);
    check("mwait_state_run", 32'(dut.r_state), 32'(RUN));
    check("mwait_cnt_hold", stall_cycles, 32'd4);
    check("mwait_nofault", 32'(mem_fault), 32'd0);
    clear_inputs();

    // Priority: freeze wins over branch and load-use.
    MemAccessM = 1'b1; dmem_ready = 1'b0;
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
    #1 check("prio_mbusy", 32'(ctl), 32'(CTL_MBUSY));
    @(negedge clk);
    dmem_ready = 1'b1;
    #1 check("prio_release", 32'(ctl), 32'(CTL_BRANCH));
    @(negedge clk);
    clear_inputs();

    // Reset during a wait abandons the access with no residual stall.
    pulse_reset();
    MemAccessM = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    MemAccessM = 1'b0;
    pulse_reset();
    #1 check("rst_mwait_ctl", 32'(ctl), 32'(CTL_NONE));
    @(negedge clk);
    check("rst_mwait_after", 32'(ctl), 32'(CTL_NONE));
    check("rst_mwait_state", 32'(dut.r_state), 32'(RUN));
    clear_inputs();

    // Timeout: fault lands on the edge after the 15th MWAIT cycle.
    pulse_reset();
    MemAccessM = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 15) begin
        check("tmo_not_yet", 32'(mem_fault), 32'd0);
        check("sat_at_15", 32'(s_stall_cycles), 32'd15);
      end
      if (i == 16) check("tmo_fault", 32'(mem_fault), 32'd1);
    end
    check("tmo_ctl", 32'(ctl), 32'(CTL_FAULT));
    check("tmo_cnt", stall_cycles, 32'd20);
    check("sat_cnt", 32'(s_stall_cycles), 32'd15);
    dmem_ready = 1'b1; MemAccessM = 1'b0; PCSrcE = 1'b1;
    #1 check("tmo_stuck_ctl", 32'(ctl), 32'(CTL_FAULT));
    @(negedge clk);
    check("tmo_sticky", 32'(mem_fault), 32'd1);
    clear_inputs();
    reset_n = 1'b0;
    #1 check("tmo_rst_fault", 32'(mem_fault), 32'd0);
    check("tmo_rst_ctl", 32'(ctl), 32'(CTL_NONE));
    reset_n = 1'b1;
    @(negedge clk);
    check("tmo_post_ctl", 32'(ctl), 32'(CTL_NONE));
    check("tmo_post_fault", 32'(mem_fault), 32'd0);
    check("tmo_post_cnt", stall_cycles, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter DMEM_TIMEOUT, default 15: maximum consecutive wait cycles on one data-memory access before fault.
REQ-002 Parameter CNT_W, default 32: width of the stall-cycle counter.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 Rs1D, Rs2D, Rs1E, Rs2E  in  5 each  source register addresses in Decode and Execute.
REQ-006 RdE, RdM, RdW  in  5 each  destination register addresses in Execute, Memory and Writeback.
REQ-007 ResultSrcE0  in  1  instruction in Execute is a load.
REQ-008 RegWriteM, RegWriteW  in  1 each  register write enables in Memory and Writeback.
REQ-009 PCSrcE  in  1  taken branch or jump resolved in Execute.
REQ-010 MemAccessM  in  1  load or store in Memory; dmem_ready  in  1  data memory completes access this cycle.
REQ-011 ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 01 ResultW, 10 ALUResultM.
REQ-012 StallF, StallD, StallE, StallM  out  1 each  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-013 FlushD, FlushE, FlushW  out  1 each  clear the IF/ID, ID/EX and MEM/WB registers.
REQ-014 mem_fault  out  1  sticky timeout flag; stall_cycles  out  CNT_W  saturating count of cycles with StallF=1.

Function
REQ-015 ForwardAE SHALL be 10 when RegWriteM=1, RdM!=0 and RdM==Rs1E; otherwise 01 when RegWriteW=1, RdW!=0 and RdW==Rs1E; otherwise 00. Memory takes priority over Writeback.
REQ-016 ForwardBE SHALL follow the same rule as ForwardAE, using Rs2E.
REQ-017 The load-use condition lw = ResultSrcE0 & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D) SHALL assert StallF, StallD and FlushE in the same cycle.
REQ-018 PCSrcE=1 SHALL assert FlushD and FlushE, and SHALL suppress the lw-driven StallF and StallD in that cycle.
REQ-019 mbusy = MemAccessM & ~dmem_ready, evaluated in state RUN or MWAIT, SHALL assert StallF, StallD, StallE, StallM and FlushW, and SHALL deassert FlushD and FlushE. A memory freeze overrides load-use and branch actions.
REQ-020 The FSM SHALL have three states: RUN, MWAIT and FAULT.
REQ-021 RUN -> MWAIT when mbusy=1; the wait counter is loaded with 1.
REQ-022 MWAIT -> RUN when dmem_ready=1; that cycle the outputs are unstalled and the wait counter clears.
REQ-023 MWAIT: the wait counter increments each cycle; when it equals DMEM_TIMEOUT with dmem_ready still 0, the FSM SHALL go MWAIT -> FAULT.
REQ-024 FAULT SHALL set mem_fault=1 and hold all four stalls at 1 and all flushes at 0, until reset.
REQ-025 MemAccessM=1 with dmem_ready=1 in RUN SHALL cause no stall, so a single-cycle access has zero added latency.
REQ-026 stall_cycles SHALL increment by 1 on every clock with StallF=1 and saturate at all-ones without wrapping.
REQ-027 Outputs other than mem_fault and stall_cycles SHALL be combinational, with zero-cycle latency from the inputs.

Reset
REQ-028 While reset_n=0, the FSM SHALL be in RUN, the wait counter SHALL be 0, mem_fault SHALL be 0 and stall_cycles SHALL be 0.
REQ-029 While reset_n=0, all Forward outputs SHALL be 00 and all Stall and Flush outputs SHALL be 0.
REQ-030 Reset asserted in MWAIT or FAULT SHALL abandon the access immediately, with no residual stall after release.

Structure
REQ-031 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, MWAIT, FAULT) and the constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
REQ-032 Forwarding selection SHALL be a sub-module fwd_sel, instantiated twice (operand A and operand B).

Verification
REQ-033 Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. Then Rs1E=0 -> 00.
REQ-034 Load-use: ResultSrcE0=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1. Same stimulus with PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1.
REQ-035 Memory wait: MemAccessM=1, dmem_ready=0 for 4 cycles then 1 -> all stalls and FlushW=1 for 4 cycles, 0 on the 5th, FSM back in RUN, stall_cycles=4.
REQ-036 Timeout: dmem_ready held 0 for 20 cycles -> FAULT after 15 wait cycles, mem_fault=1 and stalls stuck at 1. Then pulse reset_n low -> mem_fault=0, stalls 0.
REQ-037 Priority: mbusy=1 concurrent with PCSrcE=1 and lw=1 -> FlushD=FlushE=0 and all stalls 1.
REQ-038 Saturation: with CNT_W=4, 20 stall cycles -> stall_cycles=15.
